// File: rtl/alu_cmd_sequencer_if.sv
// Request/response channels and ALU tile bus of the ALU command sequencer.
// slave: the sequencer itself. master: the host-side environment driving it.
interface alu_cmd_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [1:0] req_op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [7:0] alu_data;
    logic [7:0] alu_cmd;
    logic [7:0] alu_result;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_data, alu_data, alu_cmd
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_data, alu_data, alu_cmd
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequences one ALU operation per request onto the command-driven ALU tile and
// returns the registered result; optionally skips operand loads already in the tile.
//
// state  | meaning
// IDLE   | ready for a request
// LOAD_A | alu_cmd=1, operand A on alu_data
// LOAD_B | alu_cmd=2, operand B on alu_data
// EXEC   | alu_cmd=4+op
// WAIT   | tile result register settles; captured into rsp_data
// RESP   | rsp_valid held until rsp_ready
module alu_cmd_sequencer #(
    parameter bit SKIP_RELOAD = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_cmd_sequencer_if.slave        bus,
    output logic [7:0]                op_count_o
);
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, WAIT, RESP} state_e;

    state_e     state_q, state_d;
    logic [7:0] a_q, a_d, b_q, b_d;
    logic [1:0] op_q, op_d;
    logic [7:0] cached_a_q, cached_a_d, cached_b_q, cached_b_d;
    logic       cache_valid_q, cache_valid_d;
    logic [7:0] alu_cmd_q, alu_cmd_d, alu_data_q, alu_data_d;
    logic [7:0] rsp_data_q, rsp_data_d, op_count_q, op_count_d;
    logic       skip_a, skip_b;

    // The tile keeps its operand registers, so a matching cached operand need not be resent.
    assign skip_a = SKIP_RELOAD && cache_valid_q && (a_d == cached_a_q);
    assign skip_b = SKIP_RELOAD && cache_valid_q && (b_d == cached_b_q);

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        cached_a_d    = cached_a_q;
        cached_b_d    = cached_b_q;
        cache_valid_d = cache_valid_q;
        rsp_data_d    = rsp_data_q;
        op_count_d    = op_count_q;
        alu_cmd_d     = 8'd0;
        alu_data_d    = 8'd0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    a_d  = bus.req_a;
                    b_d  = bus.req_b;
                    op_d = bus.req_op;
                    if (!skip_a)      state_d = LOAD_A;
                    else if (!skip_b) state_d = LOAD_B;
                    else              state_d = EXEC;
                end
            end
            LOAD_A: begin
                cached_a_d = a_q;
                state_d    = skip_b ? EXEC : LOAD_B;
            end
            LOAD_B: begin
                cached_b_d    = b_q;
                cache_valid_d = 1'b1;
                state_d       = EXEC;
            end
            EXEC: state_d = WAIT;
            WAIT: begin
                rsp_data_d = bus.alu_result;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered from the upcoming state so they hold for the whole state cycle.
        case (state_d)
            LOAD_A: begin
                alu_cmd_d  = 8'd1;
                alu_data_d = a_d;
            end
            LOAD_B: begin
                alu_cmd_d  = 8'd2;
                alu_data_d = b_d;
            end
            EXEC:    alu_cmd_d = 8'd4 + {6'd0, op_d};
            default: alu_cmd_d = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= 8'd0;
            b_q           <= 8'd0;
            op_q          <= 2'd0;
            cached_a_q    <= 8'd0;
            cached_b_q    <= 8'd0;
            cache_valid_q <= 1'b0;
            alu_cmd_q     <= 8'd0;
            alu_data_q    <= 8'd0;
            rsp_data_q    <= 8'd0;
            op_count_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            cached_a_q    <= cached_a_d;
            cached_b_q    <= cached_b_d;
            cache_valid_q <= cache_valid_d;
            alu_cmd_q     <= alu_cmd_d;
            alu_data_q    <= alu_data_d;
            rsp_data_q    <= rsp_data_d;
            op_count_q    <= op_count_d;
        end
    end

    assign bus.req_ready = rst_n && (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.alu_cmd   = alu_cmd_q;
    assign bus.alu_data  = alu_data_q;
    assign op_count_o    = op_count_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU tile, result scoreboard and
// command-trace checks for full, skipped, stalled, reset and wrap scenarios.
module tb_alu_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] op_count;

    alu_cmd_sequencer_if bus();

    alu_cmd_sequencer #(.SKIP_RELOAD(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .op_count_o (op_count)
    );

    always #5 clk = ~clk;

    // Command-driven ALU tile with registered operands and result.
    logic [7:0] alu_ra = 8'd0, alu_rb = 8'd0, alu_res = 8'd0;
    always @(posedge clk) begin
        case (bus.alu_cmd)
            8'd1: alu_ra <= bus.alu_data;
            8'd2: alu_rb <= bus.alu_data;
            8'd4: alu_res <= alu_ra + alu_rb;
            8'd5: alu_res <= alu_ra - alu_rb;
            8'd6: alu_res <= alu_ra & alu_rb;
            8'd7: alu_res <= alu_ra | alu_rb;
            default: ;
        endcase
    end
    assign bus.alu_result = alu_res;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_count = 8'd0;
    logic [7:0] exp_q[$];
    logic [7:0] cmd_log[$];

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [31:0] pack_cmds();
        logic [31:0] p = 32'd0;
        foreach (cmd_log[i]) p = (p << 8) | {24'd0, cmd_log[i]};
        return p;
    endfunction

    task automatic log_cmd();
        if (bus.alu_cmd != 8'd0) cmd_log.push_back(bus.alu_cmd);
    endtask

    task automatic issue_req(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        int n = 0;
        while (!bus.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        exp_q.push_back(ref_alu(a, b, op));
        cmd_log.delete();
        @(negedge clk);
        bus.req_valid = 1'b0;
        log_cmd();
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            log_cmd();
        end
        if (!bus.rsp_valid) lat = -1;
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_count = 8'd0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if (bus.req_ready !== 1'b0) begin
            fails++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready);
        end
        tests++;
        if ({bus.rsp_valid, bus.rsp_data, bus.alu_cmd, bus.alu_data, op_count} !== 33'd0) begin
            fails++;
            $display("FAIL reset_values got rsp_valid=%b rsp_data=%h cmd=%h data=%h cnt=%h want all 0",
                     bus.rsp_valid, bus.rsp_data, bus.alu_cmd, bus.alu_data, op_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL post_reset_req_ready got %b want 1", bus.req_ready);
        end
    endtask

    // Full sequences, then cache-driven skips, all back-to-back.
    task automatic test_sequences();
        string       tn[5] = '{"add", "sub_wrap", "and", "cache_skip", "partial_skip"};
        logic [7:0]  ta[5] = '{8'h30, 8'h10, 8'hF0, 8'hF0, 8'hF0};
        logic [7:0]  tb_[5] = '{8'h25, 8'h20, 8'h3C, 8'h3C, 8'h01};
        logic [1:0]  to[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [31:0] tc[5] = '{32'h010204, 32'h010205, 32'h010206, 32'h07, 32'h0204};
        int          tl[5] = '{5, 5, 5, 3, 4};
        int          lat;
        logic [7:0]  exp;
        for (int i = 0; i < 5; i++) begin
            issue_req(ta[i], tb_[i], to[i]);
            wait_rsp(lat);
            exp = exp_q.pop_front();
            tests++;
            if (lat != tl[i]) begin
                fails++; $display("FAIL %s_latency got %0d want %0d", tn[i], lat, tl[i]);
            end
            tests++;
            if (bus.rsp_data !== exp) begin
                fails++; $display("FAIL %s_data got %h want %h", tn[i], bus.rsp_data, exp);
            end
            tests++;
            if (pack_cmds() !== tc[i]) begin
                fails++; $display("FAIL %s_cmds got %h want %h", tn[i], pack_cmds(), tc[i]);
            end
            finish_rsp();
            exp_count++;
            tests++;
            if (op_count !== exp_count) begin
                fails++; $display("FAIL %s_op_count got %h want %h", tn[i], op_count, exp_count);
            end
        end
    endtask

    task automatic test_backpressure();
        int         lat;
        logic [7:0] exp;
        issue_req(8'h12, 8'h34, 2'd0);
        wait_rsp(lat);
        exp = exp_q.pop_front();
        tests++;
        if (lat != 5) begin
            fails++; $display("FAIL bp_latency got %0d want 5", lat);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if ({bus.rsp_valid, bus.rsp_data, bus.req_ready} !== {1'b1, exp, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold cycle %0d got valid=%b data=%h ready=%b want 1/%h/0",
                         i, bus.rsp_valid, bus.rsp_data, bus.req_ready, exp);
            end
            bus.req_valid = (i == 2);
            bus.req_a     = 8'h99;
            bus.req_b     = 8'h77;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        finish_rsp();
        exp_count++;
        tests++;
        if ({op_count, bus.req_ready} !== {exp_count, 1'b1}) begin
            fails++;
            $display("FAIL bp_release got cnt=%h ready=%b want %h/1", op_count, bus.req_ready, exp_count);
        end
        cmd_log.delete();
        repeat (4) begin
            @(negedge clk);
            log_cmd();
        end
        tests++;
        if ({cmd_log.size() == 0, bus.rsp_valid, op_count} !== {1'b1, 1'b0, exp_count}) begin
            fails++;
            $display("FAIL bp_no_queued_req got cmds=%0d valid=%b cnt=%h want 0/0/%h",
                     cmd_log.size(), bus.rsp_valid, op_count, exp_count);
        end
    endtask

    task automatic test_counter_wrap();
        int         lat;
        logic [7:0] exp, a, b;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            a = 8'(i * 7);
            b = 8'(i * 13);
            issue_req(a, b, 2'(i % 4));
            wait_rsp(lat);
            exp = exp_q.pop_front();
            tests++;
            if (lat < 0 || bus.rsp_data !== exp) begin
                fails++; $display("FAIL wrap_txn %0d got %h lat %0d want %h", i, bus.rsp_data, lat, exp);
            end
            finish_rsp();
            exp_count++;
            if (i == 254) begin
                tests++;
                if (op_count !== 8'hFF) begin
                    fails++; $display("FAIL wrap_ff got %h want ff", op_count);
                end
            end
        end
        tests++;
        if (op_count !== 8'h00) begin
            fails++; $display("FAIL wrap_00 got %h want 00", op_count);
        end
    endtask

    task automatic test_reset_mid_op();
        int         lat;
        logic [7:0] exp;
        issue_req(8'h55, 8'h66, 2'd0);
        @(negedge clk);
        tests++;
        if (bus.alu_cmd !== 8'd2) begin
            fails++; $display("FAIL midop_in_load_b got cmd %h want 02", bus.alu_cmd);
        end
        bus.rsp_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tests++;
            if ({bus.rsp_valid, op_count} !== {1'b0, 8'h00}) begin
                fails++;
                $display("FAIL midop_quiet cycle %0d got valid=%b cnt=%h want 0/00", i, bus.rsp_valid, op_count);
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b0;
        issue_req(8'h55, 8'h66, 2'd0);
        wait_rsp(lat);
        exp = exp_q.pop_front();
        tests++;
        if (pack_cmds() !== 32'h010204 || lat != 5) begin
            fails++; $display("FAIL midop_reload got cmds %h lat %0d want 010204 lat 5", pack_cmds(), lat);
        end
        tests++;
        if (bus.rsp_data !== exp) begin
            fails++; $display("FAIL midop_data got %h want %h", bus.rsp_data, exp);
        end
        finish_rsp();
        exp_count++;
        tests++;
        if (op_count !== exp_count) begin
            fails++; $display("FAIL midop_op_count got %h want %h", op_count, exp_count);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = 8'd0;
        bus.req_b     = 8'd0;
        bus.req_op    = 2'd0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_sequences();
        test_backpressure();
        test_counter_wrap();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Host-side initiator for the 8-bit command-driven ALU tile (cmd 1 = load A, 2 = load B, 4 = add, 5 = sub, 6 = and, 7 = or, other = hold).
- Accepts one operation per valid/ready request: operand A, operand B and a 2-bit opcode.
- Emits the correct cycle-by-cycle data/command sequence on the ALU bus, captures the registered result, and returns it on a valid/ready response channel.
- Optionally skips redundant operand loads when the operands match those last loaded.

Parameters:
SKIP_RELOAD, 1, when 1 the LOAD_A/LOAD_B cycle is skipped if the operand equals the cached last-loaded value and the cache is valid.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request offered
req_ready  output  1  sequencer can accept a request
req_a  input  8  operand A
req_b  input  8  operand B
req_op  input  2  0=add, 1=sub, 2=and, 3=or
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_data  output  8  ALU result
alu_data  output  8  to ALU data input
alu_cmd  output  8  to ALU command input
alu_result  input  8  from ALU registered output
op_count  output  8  completed-transaction counter

Behaviour:
- Reset rst_n is synchronous and active-low; clock is clk. All state is updated on the posedge of clk.
- Reset values: state=IDLE, req_ready=0 during reset, rsp_valid=0, rsp_data=0, alu_data=0, alu_cmd=0, op_count=0, cache_valid=0, cached A and B=0.
- alu_cmd and alu_data are driven from registers and are stable for each full state cycle.
- alu_cmd is 0 (NOP) in every state except LOAD_A, LOAD_B and EXEC. Values 3 and >7 are never driven.

State machine:
- IDLE: req_ready=1. On req_valid&&req_ready, latch a, b, op.
  - Next state is LOAD_A, unless SKIP_RELOAD && cache_valid && a==cachedA. In that case go to LOAD_B.
  - From LOAD_B the same skip test applies with b==cachedB; if both are skipped, go straight to EXEC.
- LOAD_A: alu_cmd=1, alu_data=a. Set cachedA=a.
- LOAD_B: alu_cmd=2, alu_data=b. Set cachedB=b and cache_valid=1. (cachedA is also valid by this point.)
- EXEC: alu_cmd=4+op, alu_data=0.
- WAIT: alu_cmd=0. The ALU output register updated at the end of EXEC; sample alu_result into rsp_data at the end of WAIT.
- RESP: rsp_valid=1. rsp_valid and rsp_data are held until rsp_ready. On rsp_valid&&rsp_ready, op_count increments (8-bit, wraps 0xFF->0x00) and state returns to IDLE.

Timing and handshake rules:
- Latency with no skips: accept at cycle 0; LOAD_A 1, LOAD_B 2, EXEC 3, WAIT 4; rsp_valid asserts in cycle 5.
- Each skipped load removes one cycle. The minimum is accept -> EXEC next cycle -> rsp_valid in cycle 3.
- req_ready=0 in every state other than IDLE. req_valid while busy is ignored; nothing is queued.
- Only one transaction is in flight. The back-to-back minimum is one IDLE cycle between the response handshake and the next accept.
- Arithmetic is performed by the ALU modulo 256. Subtraction wraps (A-B). The sequencer does no arithmetic itself.

Reset and cache:
- Reset mid-operation (any state): return to IDLE and clear cache_valid. Any pending response is discarded and rsp_valid drops on the next edge.
- alu_cmd=0 the cycle after reset is sampled.
- With SKIP_RELOAD=0, the cache is never consulted and every transaction runs LOAD_A and LOAD_B.

Test Plan:
- Add, fresh after reset: a=0x30, b=0x25, op=0. Required alu_cmd sequence is 1,2,4,0. rsp_data=0x55 with rsp_valid in cycle 5. op_count=1.
- Subtract wrap: a=0x10, b=0x20, op=1 -> rsp_data=0xF0.
- AND: a=0xF0, b=0x3C, op=2 -> 0x30.
- Cache skip (SKIP_RELOAD=1): repeat a=0xF0, b=0x3C with op=3. The only nonzero alu_cmd is 7; rsp_data=0xFC in cycle 3.
- Partial skip: then a=0xF0, b=0x01, op=0. Commands are 2,4 only; result 0xF1.
- Backpressure: hold rsp_ready=0 for 6 cycles. rsp_valid and rsp_data stay stable, req_ready=0, and a req_valid pulse in this window is not accepted. Release rsp_ready -> op_count increments once and req_ready=1 the next cycle.
- Reset mid-op: assert rsp_ready=1 and rst_n=0 during LOAD_B. rsp_valid never rises and op_count is unchanged.
  - The next identical request runs the full LOAD_A, LOAD_B sequence because the cache was invalidated.
- Counter wrap: complete 256 transactions. op_count returns to 0x00.
